// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard controller.
//   fwd_sel_e     : E-stage operand forwarding select encoding
//   mdu_state_e   : MDU occupancy tracker states
//   mdu_cnt_width : width of the MDU occupancy down-counter for a given latency
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_M    = 2'b01,
    FWD_W    = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // The counter never needs less than one bit, even for the shortest legal
  // latency.
  function automatic int mdu_cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/hazard_mdu_tracker.sv
// -----------------------------------------------------------------------------
// hazard_mdu_tracker
// Tracks how long a multi-cycle MDU op has occupied the E stage and requests
// upstream stalls until the op is allowed to advance.
//
// Parameters:
//   MDU_LAT      : total cycles an MDU op occupies E (>= 2)
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_mdu_op     : E-stage instruction is a multi-cycle MDU op
//   i_mem_wait   : pipeline frozen by a data-memory wait this cycle
//   o_mdu_stall  : hold F/D/E, bubble into M
//   o_mdu_busy   : tracker is in BUSY (registered)
// -----------------------------------------------------------------------------
module hazard_mdu_tracker
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_mdu_op,
  input  logic i_mem_wait,
  output logic o_mdu_stall,
  output logic o_mdu_busy
);

  if (MDU_LAT < 2) begin : g_bad_lat
    $error("hazard_mdu_tracker: MDU_LAT must be >= 2");
  end

  localparam int                CNT_W     = mdu_cnt_width(MDU_LAT);
  // The start cycle itself is one cycle of occupancy and the release cycle
  // (cnt==0) is another, so the counter covers the remaining MDU_LAT-2.
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MDU_LAT - 2);

  mdu_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_start;

  // A start is only taken from IDLE, so an op sitting in E during its own
  // release cycle cannot retrigger the tracker.
  assign w_start = (r_state == IDLE) & i_mdu_op & ~i_mem_wait;

  // NOTE: sequential state uses non-blocking assignments only, and only the
  // control registers are reset; this avoids ordering races between always_ff
  // blocks and makes reset behaviour explicit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= BUSY;
            r_cnt   <= CNT_START;
          end
        end
        BUSY: begin
          // The MDU keeps computing while memory stalls the pipe; only the
          // hand-off out of E has to wait for the freeze to lift.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!i_mem_wait) begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_mdu_stall = w_start | ((r_state == BUSY) & (r_cnt != '0));
  assign o_mdu_busy  = (r_state == BUSY);

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// Pipeline hazard controller for the five-stage core: E-stage forwarding
// selects, load-use stalls, redirect flushes, data-memory wait stalls and
// multi-cycle MDU occupancy stalls.
//
// Optional build macro: HAZARD_PERF_CNT_EN enables saturating 32-bit stall and
// flush performance counters; without it both counter ports read 0.
//
// Parameters: REG_ADDR_W (GPR address width), NUM_SRC (operands per instr),
//             MDU_LAT (MDU occupancy cycles, >= 2)
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   D_rs_addr, E_rs_addr       : packed source addresses, operand i at
//                                [i*REG_ADDR_W +: REG_ADDR_W]
//   E_rd_addr/E_gpr_wen        : E destination and write enable
//   E_is_load, E_mdu_op        : E instruction class
//   E_redirect                 : taken branch/jump resolved in E
//   M_/W_rd_addr, M_/W_gpr_wen : M and W destinations and write enables
//   M_dmem_req, M_dmem_ready   : M data-memory handshake
//   E_fwd_sel                  : per operand 2-bit select (fwd_sel_e)
//   F/D/E/M_stall              : hold pipeline registers
//   D/E/M/W_flush              : insert bubbles
//   mdu_busy                   : MDU tracker in BUSY
//   perf_stall_cnt/flush_cnt   : performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int MDU_LAT    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] D_rs_addr,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] E_rs_addr,
  input  logic [REG_ADDR_W-1:0]         E_rd_addr,
  input  logic                          E_gpr_wen,
  input  logic                          E_is_load,
  input  logic                          E_mdu_op,
  input  logic                          E_redirect,
  input  logic [REG_ADDR_W-1:0]         M_rd_addr,
  input  logic [REG_ADDR_W-1:0]         W_rd_addr,
  input  logic                          M_gpr_wen,
  input  logic                          W_gpr_wen,
  input  logic                          M_dmem_req,
  input  logic                          M_dmem_ready,
  output logic [2*NUM_SRC-1:0]          E_fwd_sel,
  output logic                          F_stall,
  output logic                          D_stall,
  output logic                          E_stall,
  output logic                          M_stall,
  output logic                          D_flush,
  output logic                          E_flush,
  output logic                          M_flush,
  output logic                          W_flush,
  output logic                          mdu_busy,
  output logic [31:0]                   perf_stall_cnt,
  output logic [31:0]                   perf_flush_cnt
);

  logic               w_mem_wait;
  logic               w_mdu_stall;
  logic               w_load_use;
  logic               w_hold_e;
  logic [NUM_SRC-1:0] w_d_match;

  // ---------------------------------------------------------------------------
  // Forwarding and D-operand dependency detection
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_ADDR_W-1:0] w_e_src;
    logic [REG_ADDR_W-1:0] w_d_src;

    assign w_e_src = E_rs_addr[gi*REG_ADDR_W +: REG_ADDR_W];
    assign w_d_src = D_rs_addr[gi*REG_ADDR_W +: REG_ADDR_W];

    // r0 is hard-wired zero and is never forwarded; M is younger than W and
    // therefore wins when both write the same register.
    assign E_fwd_sel[2*gi +: 2] =
        ((w_e_src != '0) && M_gpr_wen && (w_e_src == M_rd_addr)) ? FWD_M :
        ((w_e_src != '0) && W_gpr_wen && (w_e_src == W_rd_addr)) ? FWD_W :
                                                                   FWD_NONE;

    assign w_d_match[gi] = (w_d_src == E_rd_addr);
  end

  assign w_mem_wait = M_dmem_req & ~M_dmem_ready;
  assign w_load_use = E_is_load & E_gpr_wen & (E_rd_addr != '0) & (|w_d_match);

  hazard_mdu_tracker #(
    .MDU_LAT     (MDU_LAT)
  ) u_mdu_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_mdu_op    (E_mdu_op),
    .i_mem_wait  (w_mem_wait),
    .o_mdu_stall (w_mdu_stall),
    .o_mdu_busy  (mdu_busy)
  );

  // ---------------------------------------------------------------------------
  // Stall / flush arbitration
  // ---------------------------------------------------------------------------
  assign w_hold_e = w_mem_wait | w_mdu_stall;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    F_stall = 1'b0;
    D_stall = 1'b0;
    E_stall = 1'b0;
    M_stall = 1'b0;
    D_flush = 1'b0;
    E_flush = 1'b0;
    M_flush = 1'b0;
    W_flush = 1'b0;

    // A redirect kills the dependent D instruction anyway, so a load-use
    // stall on it would be wasted.
    F_stall = w_hold_e | (w_load_use & ~E_redirect);
    D_stall = F_stall;
    E_stall = w_hold_e;
    M_stall = w_mem_wait;
    W_flush = w_mem_wait;

    // A memory freeze suppresses every upstream flush; the redirect is still
    // sitting in E and simply reasserts once the freeze lifts. E is never
    // bubbled while it is being held.
    D_flush = E_redirect & ~w_mem_wait;
    E_flush = (E_redirect | w_load_use) & ~w_hold_e;
    M_flush = w_mdu_stall & ~w_mem_wait;
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (F_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if ((D_flush || E_flush) && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
